// File: rtl/div_iter_axis.sv
// Iterative radix-2 restoring divider with independent valid/ready operand
// channels and a single-cycle result pulse. Handles signed or unsigned
// operands depending on SIGNED.
module div_iter_axis #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic             dvd_held;
  logic             dvs_held;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             sign_q;
  logic             sign_r;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             dvd_fire;
  logic             dvs_fire;
  logic             start;
  logic             last;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs_c;
  logic [WIDTH-1:0] dvs_abs_c;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign dvd_fire = s_axis_dividend_tvalid & s_axis_dividend_tready;
  assign dvs_fire = s_axis_divisor_tvalid  & s_axis_divisor_tready;
  assign start    = accept & (dvd_held | dvd_fire) & (dvs_held | dvs_fire);
  assign last     = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PREP;
      PREP:    state_next = ITER;
      ITER:    if (last) state_next = DONE;
      DONE:    state_next = start ? PREP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state and held flags
  always_comb begin
    accept                 = 1'b0;
    s_axis_dividend_tready = 1'b0;
    s_axis_divisor_tready  = 1'b0;
    m_axis_dout_tvalid     = 1'b0;
    accept                 = (state == IDLE) || (state == DONE);
    s_axis_dividend_tready = accept & ~dvd_held;
    s_axis_divisor_tready  = accept & ~dvs_held;
    m_axis_dout_tvalid     = (state == DONE);
  end

  // Operand magnitudes and one restoring step with sign correction
  always_comb begin
    dvd_neg   = SIGNED & dvd_q[WIDTH-1];
    dvs_neg   = SIGNED & dvs_q[WIDTH-1];
    dvd_abs_c = dvd_neg ? -dvd_q : dvd_q;
    dvs_abs_c = dvs_neg ? -dvs_q : dvs_q;
    rem_sh    = {rem, quo[WIDTH-1]};
    trial     = rem_sh - {1'b0, dvs_abs};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
    q_fix = sign_q ? -quo_nx : quo_nx;
    r_fix = sign_r ? -rem_nx : rem_nx;
  end

  // Operand capture and held flags
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_held <= 1'b0;
      dvs_held <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
    end else begin
      if (dvd_fire) dvd_q <= s_axis_dividend_tdata;
      if (dvs_fire) dvs_q <= s_axis_divisor_tdata;
      if (start) begin
        dvd_held <= 1'b0;
        dvs_held <= 1'b0;
      end else begin
        if (dvd_fire) dvd_held <= 1'b1;
        if (dvs_fire) dvs_held <= 1'b1;
      end
    end
  end

  // Iteration datapath and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      rem               <= '0;
      quo               <= '0;
      dvs_abs           <= '0;
      sign_q            <= 1'b0;
      sign_r            <= 1'b0;
      cnt               <= '0;
      m_axis_dout_tdata <= '0;
    end else begin
      case (state)
        PREP: begin
          rem     <= '0;
          quo     <= dvd_abs_c;
          dvs_abs <= dvs_abs_c;
          sign_q  <= dvd_neg ^ dvs_neg;
          sign_r  <= dvd_neg;
          cnt     <= '0;
        end
        ITER: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CW'(1);
          if (last) m_axis_dout_tdata <= {q_fix, r_fix};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_axis.sv
// Directed bench for div_iter_axis: one signed and one unsigned instance.
module tb_div_iter_axis;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [31:0] sa = '0, sb = '0, ua = '0, ub = '0;
  logic        sav = 1'b0, sbv = 1'b0, uav = 1'b0, ubv = 1'b0;
  logic        sar, sbr, uar, ubr;
  logic [63:0] sd, ud;
  logic        sdv, udv;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  div_iter_axis #(.WIDTH(32), .SIGNED(1'b1)) u_s (
    .clk(clk), .reset(reset),
    .s_axis_dividend_tdata(sa), .s_axis_dividend_tvalid(sav), .s_axis_dividend_tready(sar),
    .s_axis_divisor_tdata(sb),  .s_axis_divisor_tvalid(sbv),  .s_axis_divisor_tready(sbr),
    .m_axis_dout_tdata(sd), .m_axis_dout_tvalid(sdv)
  );

  div_iter_axis #(.WIDTH(32), .SIGNED(1'b0)) u_u (
    .clk(clk), .reset(reset),
    .s_axis_dividend_tdata(ua), .s_axis_dividend_tvalid(uav), .s_axis_dividend_tready(uar),
    .s_axis_divisor_tdata(ub),  .s_axis_divisor_tvalid(ubv),  .s_axis_divisor_tready(ubr),
    .m_axis_dout_tdata(ud), .m_axis_dout_tvalid(udv)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic [31:0] a, input logic av,
                       input logic [31:0] b, input logic bv);
    if (sel) begin sa = a; sav = av; sb = b; sbv = bv; end
    else     begin ua = a; uav = av; ub = b; ubv = bv; end
  endtask

  function automatic logic get_tv(input bit sel);
    return sel ? sdv : udv;
  endfunction

  function automatic logic [63:0] get_d(input bit sel);
    return sel ? sd : ud;
  endfunction

  // Present both operands together on an idle DUT and wait for the pulse.
  task automatic do_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] d, output int lat);
    drive(sel, a, 1'b1, b, 1'b1);
    tick();
    drive(sel, '0, 1'b0, '0, 1'b0);
    lat = 0;
    d   = '0;
    while (lat < 100) begin
      tick();
      lat++;
      if (get_tv(sel)) begin
        d = get_d(sel);
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_tot++;
    if ({sar, sbr, uar, ubr} !== 4'b1111) $display("FAIL reset_tready got=%b want=1111", {sar, sbr, uar, ubr});
    else n_pass++;
    n_tot++;
    if ({sdv, udv} !== 2'b00) $display("FAIL reset_tvalid got=%b want=00", {sdv, udv});
    else n_pass++;
    n_tot++;
    if (sd !== 64'd0 || ud !== 64'd0) $display("FAIL reset_tdata got=%h/%h want=0", sd, ud);
    else n_pass++;
  endtask

  task automatic test_basic();
    int  lat = 0;
    bit  busy_bad = 1'b0;
    drive(1'b1, 32'd100, 1'b1, 32'd7, 1'b1);
    n_tot++;
    if ({sar, sbr} !== 2'b11) $display("FAIL basic_ready_pre got=%b want=11", {sar, sbr});
    else n_pass++;
    tick();
    drive(1'b1, '0, 1'b0, '0, 1'b0);
    while (lat < 100) begin
      if (sdv) break;
      if (sar || sbr) busy_bad = 1'b1;
      tick();
      lat++;
    end
    n_tot++;
    if (busy_bad) $display("FAIL basic_busy_tready got=1 want=0");
    else n_pass++;
    n_tot++;
    if (lat !== 33) $display("FAIL basic_latency got=%0d want=33", lat);
    else n_pass++;
    n_tot++;
    if (sd !== {32'd14, 32'd2}) $display("FAIL basic_data got=%h want=%h", sd, {32'd14, 32'd2});
    else n_pass++;
    n_tot++;
    if ({sar, sbr} !== 2'b11) $display("FAIL basic_done_tready got=%b want=11", {sar, sbr});
    else n_pass++;
    tick();
    n_tot++;
    if (sdv !== 1'b0) $display("FAIL basic_pulse_width got=%b want=0", sdv);
    else n_pass++;
  endtask

  task automatic test_signed();
    logic [31:0] va [3] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] vb [3] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [63:0] ve [3] = '{{32'hFFFF_FFFD, 32'hFFFF_FFFF},
                            {32'hFFFF_FFFD, 32'd1},
                            {32'h8000_0000, 32'd0}};
    logic [63:0] d;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      tick();
      do_op(1'b1, va[i], vb[i], d, lat);
      n_tot++;
      if (d !== ve[i] || lat !== 33)
        $display("FAIL signed_%0d got=%h lat=%0d want=%h lat=33", i, d, lat, ve[i]);
      else n_pass++;
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF9};
    logic [31:0] vb [3] = '{32'h10, 32'd0, 32'd2};
    logic [63:0] ve [3] = '{{32'h0FFF_FFFF, 32'hF},
                            {32'hFFFF_FFFF, 32'd5},
                            {32'h7FFF_FFFC, 32'd1}};
    logic [63:0] d;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      tick();
      do_op(1'b0, va[i], vb[i], d, lat);
      n_tot++;
      if (d !== ve[i] || lat !== 33)
        $display("FAIL unsigned_%0d got=%h lat=%0d want=%h lat=33", i, d, lat, ve[i]);
      else n_pass++;
    end
  endtask

  task automatic test_split();
    int lat = 0;
    bit hold_bad = 1'b0;
    tick();
    drive(1'b1, 32'd50, 1'b1, '0, 1'b0);
    tick();
    drive(1'b1, '0, 1'b0, '0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      if (sar !== 1'b0 || sbr !== 1'b1) hold_bad = 1'b1;
      if (c == 2) drive(1'b1, 32'd99, 1'b1, '0, 1'b0);
      if (c == 3) drive(1'b1, '0, 1'b0, '0, 1'b0);
      if (c == 4) drive(1'b1, '0, 1'b0, 32'd5, 1'b1);
      if (c < 4) tick();
    end
    n_tot++;
    if (hold_bad) $display("FAIL split_tready got=bad want=dvd0_dvs1");
    else n_pass++;
    tick();
    drive(1'b1, '0, 1'b0, '0, 1'b0);
    while (lat < 100 && !sdv) begin
      tick();
      lat++;
    end
    n_tot++;
    if (lat !== 33) $display("FAIL split_latency got=%0d want=33", lat);
    else n_pass++;
    n_tot++;
    if (sd !== {32'd10, 32'd0}) $display("FAIL split_data got=%h want=%h", sd, {32'd10, 32'd0});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    int          lat;
    int          k = 0;
    bit          stable_bad = 1'b0;
    tick();
    do_op(1'b1, 32'd20, 32'd6, d, lat);
    n_tot++;
    if (d !== {32'd3, 32'd2}) $display("FAIL b2b_first got=%h want=%h", d, {32'd3, 32'd2});
    else n_pass++;
    drive(1'b1, 32'd9, 1'b1, 32'd3, 1'b1);
    tick();
    drive(1'b1, '0, 1'b0, '0, 1'b0);
    k = 1;
    while (k < 100 && !sdv) begin
      if (sd !== {32'd3, 32'd2}) stable_bad = 1'b1;
      tick();
      k++;
    end
    n_tot++;
    if (stable_bad) $display("FAIL b2b_stable got=changed want=%h", {32'd3, 32'd2});
    else n_pass++;
    n_tot++;
    if (k !== 34) $display("FAIL b2b_spacing got=%0d want=34", k);
    else n_pass++;
    n_tot++;
    if (sd !== {32'd3, 32'd0}) $display("FAIL b2b_second got=%h want=%h", sd, {32'd3, 32'd0});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    int          lat;
    bit          pulse = 1'b0;
    tick();
    drive(1'b1, 32'd1000, 1'b1, 32'd3, 1'b1);
    tick();
    drive(1'b1, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 11; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tot++;
    if ({sar, sbr} !== 2'b11) $display("FAIL rstmid_tready got=%b want=11", {sar, sbr});
    else n_pass++;
    n_tot++;
    if (sd !== 64'd0 || sdv !== 1'b0) $display("FAIL rstmid_out got=%h/%b want=0/0", sd, sdv);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      if (sdv) pulse = 1'b1;
      tick();
    end
    n_tot++;
    if (pulse) $display("FAIL rstmid_pulse got=1 want=0");
    else n_pass++;
    do_op(1'b1, 32'd8, 32'd2, d, lat);
    n_tot++;
    if (d !== {32'd4, 32'd0} || lat !== 33)
      $display("FAIL rstmid_next got=%h lat=%0d want=%h lat=33", d, lat, {32'd4, 32'd0});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_unsigned();
    test_split();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
